usb_fifo_sched: RTL and testbench
=================================

Name: usb_fifo_sched

Overview:
- Time-multiplexes the FX2LP slave-FIFO bus between an RX path (host→FPGA, EP2 OUT) and a TX path (FPGA→host, EP6 IN).
- Sequences FIFOADR, SLOE, SLRD, SLWR and PKTEND; owns the FDATA tristate.
- Arbitrates round-robin, with a per-grant burst limit so neither direction starves.
- Sits between the FX2LP pins and the user-side RX sink / TX source logic.

Parameters:
- BURST_MAX, 256: max words per grant before re-arbitration; range 1..65535.
- CNT_W, 16: width of burst counter and word counters.

Ports:
- CLKOUT  in  1  system clock (also drives IFCLK = ~CLKOUT)
- rst_n  in  1  reset
- FLAGA  in  1  EP2 OUT empty flag, active-low (1 = data available)
- FLAGD  in  1  EP6 IN full flag, active-low (1 = space available)
- FDATA  inout  16  slave-FIFO data bus
- IFCLK  out  1  ~CLKOUT
- FIFOADR  out  2  endpoint select: 00 = EP2, 10 = EP6
- SLOE  out  1  output enable, active-low
- SLRD  out  1  read strobe, active-low
- SLWR  out  1  write strobe, active-low
- PKTEND  out  1  packet commit, active-low
- rx_ready  in  1  RX sink can accept a word this cycle
- rx_data  out  16  word read from EP2
- rx_valid  out  1  one-cycle pulse; rx_data valid
- tx_data  in  16  word to write to EP6
- tx_valid  in  1  TX source has a word
- tx_ready  out  1  word consumed this cycle
- tx_flush  in  1  pulse: commit a short EP6 packet
- state  out  3  current FSM state (for LEDs)
- rx_words  out  CNT_W  total words read, wraps
- tx_words  out  CNT_W  total words written, wraps

Behaviour:
- Reset is asynchronous, active-low, on CLKOUT.
  - Reset values: state = IDLE; FIFOADR = 10; SLOE = SLRD = SLWR = PKTEND = 1; FDATA = Z; rx_valid = 0; rx_data = 0; counters = 0; last_grant = TX; flush_pend = 0.
  - Reset mid-burst forces all strobes high and FDATA to Z immediately.
- State encoding: IDLE = 000, RD_SEL = 001, RD_OE = 010, RD_DATA = 011, RD_END = 100, WR_SEL = 101, WR_DATA = 110, WR_PKT = 111.
- Requests are evaluated in IDLE only:
  - rd_req = FLAGA & rx_ready
  - wr_req = (FLAGD & tx_valid) | (flush_pend & FLAGD)
- Arbitration:
  - Single request: grant it.
  - Both requests: grant the direction opposite to last_grant.
  - last_grant updates on entry to RD_SEL or WR_SEL.
- Read path:
  - RD_SEL: FIFOADR = 00, one cycle.
  - RD_OE: SLOE = 0, one cycle of bus turnaround.
  - RD_DATA: SLOE = 0; SLRD = ~(FLAGA & rx_ready) combinationally.
    - Each cycle with SLRD = 0: rx_data <= FDATA, rx_valid = 1 next cycle, burst and rx_words increment.
    - Exit to RD_END when FLAGA = 0, rx_ready = 0, or burst == BURST_MAX after the strobe.
  - RD_END: SLOE = 1, one cycle, then IDLE.
  - FDATA is never driven in any read state.
- Write path:
  - WR_SEL: FIFOADR = 10, one cycle.
  - WR_DATA: FDATA = tx_data; SLWR = tx_ready = ~... i.e. the strobe fires when tx_valid & FLAGD.
    - tx_ready = tx_valid & FLAGD; SLWR = ~(tx_valid & FLAGD).
    - Each strobe increments burst and tx_words.
    - Exit when FLAGD = 0, tx_valid = 0, or burst limit is reached.
    - If exiting with flush_pend = 1 and FLAGD = 1, go to WR_PKT; otherwise go to IDLE.
- FDATA is driven only in WR_SEL, WR_DATA and WR_PKT; Z otherwise. RD and WR never overlap; IDLE always separates them.
- Burst counter clears in IDLE. Word counters wrap modulo 2^CNT_W.
- FIFOADR holds its last value in IDLE and RD_END.
- Simultaneous events: FLAGA and FLAGD both 1 with both requests → round-robin. FLAGD falling in the same cycle as tx_valid → no strobe, exit to IDLE.

Optional Feature:
- Macro: USB_PKTEND_EN.
- Defined:
  - tx_flush sets flush_pend.
  - WR_PKT drives PKTEND = 0 for exactly one cycle with SLWR = 1, clears flush_pend, then returns to IDLE.
  - A flush with no data pending still enters WR_SEL → WR_PKT (zero-length packet).
- Undefined:
  - tx_flush is ignored; PKTEND is tied to 1; WR_PKT is unreachable and decodes to IDLE.

Test Plan:
- Reset, then FLAGA = 1, rx_ready = 1, FDATA = 0x0000..0x0009, FLAGA drops after 10 words → sequence 000,001,010,011(×10),100,000. Expect 10 rx_valid pulses with matching data, rx_words = 10, and SLOE low only in RD_OE/RD_DATA.
- tx_valid held 1 with an incrementing tx_data, FLAGD = 1, BURST_MAX = 4 → exactly 4 SLWR lows per grant, FIFOADR = 10, FDATA = Z between bursts.
- FLAGA = FLAGD = 1, rx_ready = tx_valid = 1, BURST_MAX = 8 → grants alternate RD, WR, RD, WR, starting with RD after reset; 8 words each.
- Write 3 words, then tx_flush pulse (USB_PKTEND_EN defined) → one PKTEND low cycle after the 3rd SLWR, with SLWR = 1 during it. With the macro undefined, PKTEND stays 1.
- FLAGD drops mid-burst after 5 words → no 6th SLWR, tx_ready = 0 that cycle, state returns to IDLE.
- rst_n asserted in RD_DATA → same cycle: SLOE = SLRD = 1, FIFOADR = 10, state = 000; no spurious rx_valid.

Source files
------------

// File: rtl/usb_fifo_sched.sv
// FX2LP slave-FIFO scheduler: round-robin EP2 OUT reads / EP6 IN writes with per-grant burst limit.
// Latency: 3 cycles IDLE->first read strobe, 2 cycles IDLE->first write strobe; rx_valid 1 cycle after SLRD.
// Backpressure: strobes qualified by FLAGA&rx_ready / FLAGD&tx_valid; `USB_PKTEND_EN enables tx_flush->PKTEND.
`timescale 1ns/1ps
module usb_fifo_sched #(
    parameter int BURST_MAX = 256,
    parameter int CNT_W     = 16
) (
    input  logic             CLKOUT,
    input  logic             rst_n,
    input  logic             FLAGA,
    input  logic             FLAGD,
    inout  wire  [15:0]      FDATA,
    output logic             IFCLK,
    output logic [1:0]       FIFOADR,
    output logic             SLOE,
    output logic             SLRD,
    output logic             SLWR,
    output logic             PKTEND,
    input  logic             rx_ready,
    output logic [15:0]      rx_data,
    output logic             rx_valid,
    input  logic [15:0]      tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             tx_flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] rx_words,
    output logic [CNT_W-1:0] tx_words
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        RD_SEL  = 3'b001,
        RD_OE   = 3'b010,
        RD_DATA = 3'b011,
        RD_END  = 3'b100,
        WR_SEL  = 3'b101,
        WR_DATA = 3'b110,
        WR_PKT  = 3'b111
    } st_t;

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    st_t              st;
    logic             last_grant;   // 1 = last grant went to TX
    logic             flush_pend;
    logic [CNT_W-1:0] burst;
    logic [CNT_W-1:0] burst_inc;
    logic             burst_last;
    logic             rd_stb;
    logic             wr_stb;
    logic             rd_req;
    logic             wr_req;
    logic             grant_rd;
    logic             fdata_oe;

    always_comb begin
        rd_stb     = (st == RD_DATA) && FLAGA && rx_ready;
        wr_stb     = (st == WR_DATA) && tx_valid && FLAGD;
        rd_req     = FLAGA && rx_ready;
        wr_req     = (FLAGD && tx_valid) || (flush_pend && FLAGD);
        // With both requesting, the side that did not win last time goes next.
        grant_rd   = rd_req && (!wr_req || last_grant);
        burst_inc  = burst + ONE;
        burst_last = (burst_inc == BURST_LIM);
        fdata_oe   = (st == WR_SEL) || (st == WR_DATA) || (st == WR_PKT);
    end

    assign FDATA    = fdata_oe ? tx_data : 16'hzzzz;
    assign IFCLK    = ~CLKOUT;
    assign SLOE     = !((st == RD_OE) || (st == RD_DATA));
    assign SLRD     = !rd_stb;
    assign SLWR     = !wr_stb;
    assign tx_ready = wr_stb;
    assign state    = st;

`ifdef USB_PKTEND_EN
    assign PKTEND = (st != WR_PKT);
`else
    logic unused_flush;
    assign unused_flush = tx_flush;
    assign flush_pend   = 1'b0;
    assign PKTEND       = 1'b1;
`endif

    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            FIFOADR    <= 2'b10;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_words   <= '0;
            tx_words   <= '0;
            burst      <= '0;
            last_grant <= 1'b1;
`ifdef USB_PKTEND_EN
            flush_pend <= 1'b0;
`endif
        end else begin
            rx_valid <= rd_stb;
            if (rd_stb) begin
                rx_data  <= FDATA;
                rx_words <= rx_words + ONE;
            end
            if (wr_stb)
                tx_words <= tx_words + ONE;
            if (rd_stb || wr_stb)
                burst <= burst_inc;
`ifdef USB_PKTEND_EN
            if (st == WR_PKT)
                flush_pend <= 1'b0;
            else if (tx_flush)
                flush_pend <= 1'b1;
`endif
            case (st)
                IDLE: begin
                    burst <= '0;
                    if (grant_rd) begin
                        st         <= RD_SEL;
                        FIFOADR    <= 2'b00;
                        last_grant <= 1'b0;
                    end else if (wr_req) begin
                        st         <= WR_SEL;
                        FIFOADR    <= 2'b10;
                        last_grant <= 1'b1;
                    end
                end
                RD_SEL:  st <= RD_OE;
                RD_OE:   st <= RD_DATA;
                RD_DATA: if (!rd_stb || burst_last) st <= RD_END;
                RD_END:  st <= IDLE;
`ifdef USB_PKTEND_EN
                // A flush with nothing to send goes straight to a zero-length packet.
                WR_SEL:  st <= (flush_pend && !tx_valid && FLAGD) ? WR_PKT : WR_DATA;
                WR_DATA: if (!wr_stb || burst_last) st <= (flush_pend && FLAGD) ? WR_PKT : IDLE;
                WR_PKT:  st <= IDLE;
`else
                WR_SEL:  st <= WR_DATA;
                WR_DATA: if (!wr_stb || burst_last) st <= IDLE;
`endif
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fifo_sched.sv
// Bench for usb_fifo_sched: FX2 endpoint queues as reference, directed table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_usb_fifo_sched;
    localparam int BMAX = 4;

    logic        CLKOUT = 1'b0;
    logic        rst_n = 1'b0;
    logic        FLAGA = 1'b0, FLAGD = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0, tx_flush = 1'b0;
    logic [15:0] tx_data = 16'h0;
    wire  [15:0] FDATA;
    logic        IFCLK, SLOE, SLRD, SLWR, PKTEND, rx_valid, tx_ready;
    logic [1:0]  FIFOADR;
    logic [15:0] rx_data, rx_words, tx_words;
    logic [2:0]  state;
    logic [15:0] fx_drv = 16'h0;

    // The FX2 drives the bus whenever output enable is asserted.
    assign FDATA = SLOE ? 16'hzzzz : fx_drv;
    always #5 CLKOUT = ~CLKOUT;

    usb_fifo_sched #(.BURST_MAX(BMAX), .CNT_W(16)) dut (
        .CLKOUT(CLKOUT), .rst_n(rst_n), .FLAGA(FLAGA), .FLAGD(FLAGD), .FDATA(FDATA),
        .IFCLK(IFCLK), .FIFOADR(FIFOADR), .SLOE(SLOE), .SLRD(SLRD), .SLWR(SLWR), .PKTEND(PKTEND),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush),
        .state(state), .rx_words(rx_words), .tx_words(tx_words)
    );

    typedef struct packed {
        logic       fa;
        logic       rdy;
        logic [2:0] st;
        logic       sloe;
        logic       slrd;
        logic [1:0] adr;
        logic       rv;
    } vec_t;

    vec_t        tbl [17];
    int          n_pass = 0, n_fail = 0;
    logic [15:0] ep2[$];
    logic [15:0] exp_rxq[$];
    int          rd_cnt = 0, wr_cnt = 0, pkt_cnt = 0;
    logic [15:0] tx_next = 16'h1000;
    int          tx_avail = 0;
    logic        fa = 1'b0, rdy = 1'b0, fd = 1'b0, txv_en = 1'b0, flush_req = 1'b0;
    int          dir = 0;
    int          grants[$];
    int          runs[$];
`ifdef USB_PKTEND_EN
    logic        flush_out = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        FLAGA    = fa;
        rx_ready = rdy;
        FLAGD    = fd;
        tx_valid = txv_en && (tx_avail > 0);
        tx_data  = tx_next;
        tx_flush = flush_req;
        fx_drv   = (ep2.size() > 0) ? ep2[0] : 16'h0;
`ifdef USB_PKTEND_EN
        if (flush_req) flush_out = 1'b1;
`endif
    endtask

    // Protocol rules and endpoint scoreboard, applied every cycle.
    task automatic observe();
        if (rx_valid) begin
            if (exp_rxq.size() == 0) chk("rx_spurious", rx_valid, 1'b0);
            else chk("rx_data", rx_data, exp_rxq.pop_front());
        end
        if (!SLOE) chk("sloe_state", (state == 3'd2) || (state == 3'd3), 1'b1);
        if (!SLRD) begin
            chk("slrd_cond", FLAGA && rx_ready, 1'b1);
            chk("slrd_adr", FIFOADR, 2'b00);
            if (ep2.size() > 0) exp_rxq.push_back(ep2.pop_front());
            rd_cnt++;
            if (dir != 1) begin grants.push_back(1); runs.push_back(0); dir = 1; end
            runs[runs.size()-1] = runs[runs.size()-1] + 1;
            chk("rd_burst", runs[runs.size()-1] <= BMAX, 1'b1);
        end
        if (!SLWR || tx_ready) chk("tx_ready", tx_ready, !SLWR);
        if (!SLWR) begin
            chk("slwr_cond", FLAGD && tx_valid, 1'b1);
            chk("slwr_adr", FIFOADR, 2'b10);
            chk("slwr_sloe", SLOE, 1'b1);
            chk("wr_fdata", FDATA, tx_next);
            wr_cnt++;
            tx_next = tx_next + 16'd1;
            if (tx_avail > 0) tx_avail--;
            if (dir != 2) begin grants.push_back(2); runs.push_back(0); dir = 2; end
            runs[runs.size()-1] = runs[runs.size()-1] + 1;
            chk("wr_burst", runs[runs.size()-1] <= BMAX, 1'b1);
        end
        if (!PKTEND) begin
            pkt_cnt++;
`ifdef USB_PKTEND_EN
            chk("pkt_slwr", SLWR, 1'b1);
            chk("pkt_pending", flush_out, 1'b1);
            flush_out = 1'b0;
`else
            chk("pktend_tied", PKTEND, 1'b1);
`endif
        end
        if (state == 3'd0) dir = 0;
    endtask

    task automatic cycle();
        @(negedge CLKOUT);
        drive();
        #1;
        observe();
    endtask

    initial begin
        int k;
        int base;
        int pk0;
        tbl[0]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 2'b00, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 2'b00, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0};
        for (int i = 0; i < 10; i++) ep2.push_back(16'(i));

        // Reset values
        repeat (3) @(negedge CLKOUT);
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_adr", FIFOADR, 2'b10);
        chk("rst_strobes", {SLOE, SLRD, SLWR, PKTEND}, 4'hF);
        chk("rst_rx", {rx_valid, rx_data}, 17'h0);
        chk("rst_words", {rx_words, tx_words}, 32'h0);
        chk("rst_txrdy", tx_ready, 1'b0);
        chk("ifclk", IFCLK, 1'b1);
        @(negedge CLKOUT);
        rst_n = 1'b1;

        // Directed read sequence: short burst ended by rx_ready, then burst-limited grant
        for (int i = 0; i < 17; i++) begin
            fa  = tbl[i].fa;
            rdy = tbl[i].rdy;
            cycle();
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_sloe", i), SLOE, tbl[i].sloe);
            chk($sformatf("tbl%0d_slrd", i), SLRD, tbl[i].slrd);
            chk($sformatf("tbl%0d_adr", i), FIFOADR, tbl[i].adr);
            chk($sformatf("tbl%0d_rv", i), rx_valid, tbl[i].rv);
        end
        chk("tbl_rx_words", rx_words, 16'd6);
        chk("tbl_rxq_empty", exp_rxq.size(), 0);

        // Three words then a flush pulse
        fa = 1'b0; fd = 1'b1; txv_en = 1'b1; tx_avail = 3;
        base = wr_cnt; k = 0;
        while (wr_cnt < base + 3 && k < 40) begin cycle(); k++; end
        chk("flush_wr3", wr_cnt - base, 3);
        pk0 = pkt_cnt;
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        repeat (15) cycle();
        chk("flush_no_extra_wr", wr_cnt - base, 3);
`ifdef USB_PKTEND_EN
        chk("flush_pkt_cnt", pkt_cnt - pk0, 1);
`else
        chk("flush_pkt_cnt", pkt_cnt - pk0, 0);
`endif

        // FLAGD falls mid-burst with tx_valid still high
        tx_avail = 100; fd = 1'b1; txv_en = 1'b1;
        base = wr_cnt; k = 0;
        while (wr_cnt < base + 2 && k < 40) begin cycle(); k++; end
        chk("fd_drop_wr2", wr_cnt - base, 2);
        fd = 1'b0;
        cycle();
        chk("fd_drop_state", state, 3'd6);
        chk("fd_drop_slwr", SLWR, 1'b1);
        chk("fd_drop_txrdy", tx_ready, 1'b0);
        cycle();
        chk("fd_drop_idle", state, 3'd0);
        chk("fd_drop_words", wr_cnt - base, 2);
        txv_en = 1'b0;

        // Reset asserted while in RD_DATA
        for (int i = 0; i < 8; i++) ep2.push_back(16'hA000 + 16'(i));
        fa = 1'b1; rdy = 1'b1; k = 0;
        cycle();
        while (state != 3'd3 && k < 12) begin cycle(); k++; end
        chk("rst_mid_reach", state, 3'd3);
        @(negedge CLKOUT);
        drive();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_state", state, 3'd0);
        chk("rst_mid_strobes", {SLOE, SLRD, SLWR}, 3'b111);
        chk("rst_mid_adr", FIFOADR, 2'b10);
        chk("rst_mid_rv", rx_valid, 1'b0);
        exp_rxq.delete(); grants.delete(); runs.delete();
        rd_cnt = 0; wr_cnt = 0; dir = 0;
        fa = 1'b0; rdy = 1'b0;
        @(negedge CLKOUT);
        drive();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_rv", rx_valid, 1'b0);
        chk("post_rst_words", rx_words, 16'd0);

        // Both directions saturated: alternate grants, RD first
        for (int i = 0; i < 40; i++) ep2.push_back(16'hB000 + 16'(i));
        fa = 1'b1; rdy = 1'b1; fd = 1'b1; txv_en = 1'b1; tx_avail = 1000;
        repeat (80) cycle();
        chk("rr_grants", grants.size() >= 4, 1'b1);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_dir%0d", i), grants[i], (i % 2 == 0) ? 1 : 2);
                chk($sformatf("rr_len%0d", i), runs[i], BMAX);
            end
        end

        // Random traffic against the endpoint model
        tx_avail = 0;
        for (int c = 0; c < 3000; c++) begin
            if (ep2.size() < 4 && ($urandom % 3) == 0)
                for (int j = 0; j < int'($urandom_range(1, 6)); j++) ep2.push_back(16'($urandom));
            if (tx_avail == 0 && ($urandom % 3) == 0) tx_avail = int'($urandom_range(1, 12));
            fa        = (ep2.size() > 0) && (($urandom % 8) != 0);
            rdy       = ($urandom % 4) != 0;
            fd        = ($urandom % 6) != 0;
            txv_en    = ($urandom % 4) != 0;
            flush_req = PKTEND && (($urandom % 50) == 0);
            cycle();
        end
        fa = 1'b0; rdy = 1'b0; fd = 1'b1; txv_en = 1'b0; flush_req = 1'b0;
        repeat (20) cycle();
        chk("drain_rxq", exp_rxq.size(), 0);
        chk("drain_state", state, 3'd0);
        chk("rx_words", rx_words, rd_cnt[15:0]);
        chk("tx_words", tx_words, wr_cnt[15:0]);
`ifdef USB_PKTEND_EN
        chk("drain_flush", flush_out, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
